// File: rtl/text_console_pkg.sv
// Shared types and constants for the text console.
// Holds the FSM encoding, control characters and buffer geometry.
package text_console_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ESC,
        S_ESC_Y1,
        S_ESC_Y2,
        S_CLR_SCREEN,
        S_CLR_ROW
    } state_t;

    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] ESC   = 8'h1B;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_Y  = 8'h59;
    localparam logic [7:0] CH_P  = 8'h70;
    localparam logic [7:0] CH_Q  = 8'h71;

    localparam int ROW_STRIDE = 64;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console_byte_fifo.sv
// Small synchronous byte FIFO with show-ahead read data.
// Pushes while full are ignored; the caller flags the loss.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_data  = r_mem[r_rd[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointer update; extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Storage array, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/text_console.sv
// Byte-stream terminal front end for the LCD character buffer.
// Handles cursor, escapes, clears and scroll via a row-base offset.
module text_console
    import text_console_pkg::*;
#(
    parameter int COLS       = 40,
    parameter int ROWS       = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    output logic       wr_en,
    output logic [8:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [2:0] row_base,
    output logic [5:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       busy,
    output logic       overflow
);

    localparam int         COL_W    = $clog2(ROW_STRIDE);
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COL_W-1:0]   r_cx;
    logic [COL_W-1:0]   w_cx_nxt;
    logic [2:0]         r_cy;
    logic [2:0]         w_cy_nxt;
    logic [2:0]         r_base;
    logic [2:0]         w_base_nxt;
    logic               r_inv;
    logic               w_inv_nxt;
    logic               r_ovf;
    logic [7:0]         r_byte;
    logic               r_vld;
    logic [2:0]         r_clr_row;
    logic [2:0]         w_clr_row_nxt;
    logic [5:0]         r_clr_col;
    logic [5:0]         w_clr_col_nxt;
    logic [2:0]         r_ypend;
    logic [2:0]         w_ypend_nxt;
    logic               r_wr_en;
    logic               w_wr_en_nxt;
    logic [8:0]         r_wr_addr;
    logic [8:0]         w_wr_addr_nxt;
    logic [7:0]         r_wr_data;
    logic [7:0]         w_wr_data_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               w_nl;

    logic [7:0]         w_fifo_data;
    logic               w_full;
    logic               w_empty;
    logic               w_pop_st;
    logic               w_pop;
    logic [7:0]         w_off;
    logic [2:0]         w_ysat;
    logic [5:0]         w_xsat;
    logic [2:0]         w_phys;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (rx_strobe),
        .i_data  (rx_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop_st = (r_state == S_IDLE)   ||
                      (r_state == S_ESC)    ||
                      (r_state == S_ESC_Y1) ||
                      (r_state == S_ESC_Y2);
    assign w_pop    = w_pop_st && !w_empty;

    assign w_off  = r_byte - SPACE;
    assign w_ysat = (r_byte < SPACE)      ? 3'd0 :
                    (w_off > 8'(LAST_ROW)) ? LAST_ROW :
                    w_off[2:0];
    assign w_xsat = (r_byte < SPACE)      ? 6'd0 :
                    (w_off > 8'(LAST_COL)) ? LAST_COL :
                    w_off[5:0];
    assign w_phys = r_cy + r_base;

    // Next-state, cursor, clear counters and write port.
    always_comb begin
        w_state_nxt   = r_state;
        w_cx_nxt      = r_cx;
        w_cy_nxt      = r_cy;
        w_base_nxt    = r_base;
        w_inv_nxt     = r_inv;
        w_clr_row_nxt = r_clr_row;
        w_clr_col_nxt = r_clr_col;
        w_ypend_nxt   = r_ypend;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_busy_nxt    = 1'b0;
        w_nl          = 1'b0;

        case (r_state)
            S_IDLE: if (r_vld) begin
                unique case (1'b1)
                    is_printable(r_byte): begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = {w_phys, r_cx};
                        w_wr_data_nxt = {r_inv, r_byte[6:0]};
                        if (r_cx == LAST_COL) begin
                            w_cx_nxt = '0;
                            w_nl     = 1'b1;
                        end else begin
                            w_cx_nxt = r_cx + 1'b1;
                        end
                    end
                    (r_byte == CR): w_cx_nxt = '0;
                    (r_byte == LF): w_nl = 1'b1;
                    (r_byte == BS): begin
                        if (r_cx != '0) w_cx_nxt = r_cx - 1'b1;
                    end
                    (r_byte == FF): begin
                        w_state_nxt   = S_CLR_SCREEN;
                        w_clr_row_nxt = '0;
                        w_clr_col_nxt = '0;
                    end
                    (r_byte == ESC): w_state_nxt = S_ESC;
                    default: ;
                endcase
            end
            S_ESC: if (r_vld) begin
                w_state_nxt = S_IDLE;
                unique case (1'b1)
                    (r_byte == CH_P): w_inv_nxt = 1'b1;
                    (r_byte == CH_Q): w_inv_nxt = 1'b0;
                    (r_byte == CH_E): begin
                        w_state_nxt   = S_CLR_SCREEN;
                        w_clr_row_nxt = '0;
                        w_clr_col_nxt = '0;
                    end
                    (r_byte == CH_K): begin
                        w_state_nxt   = S_CLR_ROW;
                        w_clr_row_nxt = w_phys;
                        w_clr_col_nxt = r_cx;
                    end
                    (r_byte == CH_Y): w_state_nxt = S_ESC_Y1;
                    default: ;
                endcase
            end
            S_ESC_Y1: if (r_vld) begin
                w_ypend_nxt = w_ysat;
                w_state_nxt = S_ESC_Y2;
            end
            S_ESC_Y2: if (r_vld) begin
                w_cy_nxt    = r_ypend;
                w_cx_nxt    = w_xsat;
                w_state_nxt = S_IDLE;
            end
            S_CLR_SCREEN: begin
                w_wr_en_nxt   = 1'b1;
                w_busy_nxt    = 1'b1;
                w_wr_addr_nxt = {r_clr_row, r_clr_col};
                w_wr_data_nxt = SPACE;
                if (r_clr_col == LAST_COL) begin
                    w_clr_col_nxt = '0;
                    if (r_clr_row == LAST_ROW) begin
                        w_state_nxt = S_IDLE;
                        w_base_nxt  = '0;
                        w_cx_nxt    = '0;
                        w_cy_nxt    = '0;
                    end else begin
                        w_clr_row_nxt = r_clr_row + 1'b1;
                    end
                end else begin
                    w_clr_col_nxt = r_clr_col + 1'b1;
                end
            end
            S_CLR_ROW: begin
                w_wr_en_nxt   = 1'b1;
                w_busy_nxt    = 1'b1;
                w_wr_addr_nxt = {r_clr_row, r_clr_col};
                w_wr_data_nxt = SPACE;
                if (r_clr_col == LAST_COL) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_clr_col_nxt = r_clr_col + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Newline: move down, or scroll and blank the new bottom row.
        if (w_nl) begin
            if (r_cy != LAST_ROW) begin
                w_cy_nxt = r_cy + 1'b1;
            end else begin
                w_base_nxt    = r_base + 1'b1;
                w_state_nxt   = S_CLR_ROW;
                w_clr_row_nxt = r_cy + r_base + 3'd1;
                w_clr_col_nxt = '0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Staged byte: loaded on pop, consumed by any popping state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte <= '0;
            r_vld  <= 1'b0;
        end else if (w_pop) begin
            r_byte <= w_fifo_data;
            r_vld  <= 1'b1;
        end else if (w_pop_st) begin
            r_vld  <= 1'b0;
        end
    end

    // Cursor, attributes, counters and registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cx      <= '0;
            r_cy      <= '0;
            r_base    <= '0;
            r_inv     <= 1'b0;
            r_ovf     <= 1'b0;
            r_clr_row <= '0;
            r_clr_col <= '0;
            r_ypend   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_cx      <= w_cx_nxt;
            r_cy      <= w_cy_nxt;
            r_base    <= w_base_nxt;
            r_inv     <= w_inv_nxt;
            r_clr_row <= w_clr_row_nxt;
            r_clr_col <= w_clr_col_nxt;
            r_ypend   <= w_ypend_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_busy    <= w_busy_nxt;
            if (rx_strobe && w_full) r_ovf <= 1'b1;
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign row_base = r_base;
    assign cursor_x = r_cx;
    assign cursor_y = r_cy;
    assign busy     = r_busy;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console.
// Byte table plus hand sequences; writes checked via a queue.
module tb_text_console;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_strobe = 1'b0;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] row_base;
    logic [5:0] cursor_x;
    logic [2:0] cursor_y;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b1;

    typedef struct {
        logic [8:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] b;
        logic       w;
        logic [8:0] a;
        logic [7:0] d;
        logic [5:0] cx;
        logic [2:0] cy;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tv[27];

    text_console dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .row_base  (row_base),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic expect_wr(input logic [8:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data   = b;
        rx_strobe = 1'b1;
        @(posedge clk);
        #1 rx_strobe = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic w,
                                input logic [8:0] a, input logic [7:0] d,
                                input logic [5:0] cx, input logic [2:0] cy);
        vec_t v;
        v.b = b; v.w = w; v.a = a; v.d = d; v.cx = cx; v.cy = cy;
        return v;
    endfunction

    // Scoreboard: every write must match the head of the queue.
    always @(negedge clk) begin
        if (mon_on && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr: addr %0h data %0h, none expected",
                         wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {23'd0, wr_addr}, {23'd0, e.a});
                chk("wr_data", {24'd0, wr_data}, {24'd0, e.d});
            end
        end
    end

    initial begin
        tv[0]  = mk(8'h1B, 0, 9'h000, 8'h00,  1, 0);
        tv[1]  = mk(8'h70, 0, 9'h000, 8'h00,  1, 0);
        tv[2]  = mk(8'h42, 1, 9'h001, 8'hC2,  2, 0);
        tv[3]  = mk(8'h1B, 0, 9'h000, 8'h00,  2, 0);
        tv[4]  = mk(8'h71, 0, 9'h000, 8'h00,  2, 0);
        tv[5]  = mk(8'h43, 1, 9'h002, 8'h43,  3, 0);
        tv[6]  = mk(8'h08, 0, 9'h000, 8'h00,  2, 0);
        tv[7]  = mk(8'h7F, 0, 9'h000, 8'h00,  2, 0);
        tv[8]  = mk(8'h0D, 0, 9'h000, 8'h00,  0, 0);
        tv[9]  = mk(8'h0A, 0, 9'h000, 8'h00,  0, 1);
        tv[10] = mk(8'h95, 0, 9'h000, 8'h00,  0, 1);
        tv[11] = mk(8'h1B, 0, 9'h000, 8'h00,  0, 1);
        tv[12] = mk(8'h59, 0, 9'h000, 8'h00,  0, 1);
        tv[13] = mk(8'h23, 0, 9'h000, 8'h00,  0, 1);
        tv[14] = mk(8'h47, 0, 9'h000, 8'h00, 39, 3);
        tv[15] = mk(8'h5A, 1, 9'h0E7, 8'h5A,  0, 4);
        tv[16] = mk(8'h08, 0, 9'h000, 8'h00,  0, 4);
        tv[17] = mk(8'h1B, 0, 9'h000, 8'h00,  0, 4);
        tv[18] = mk(8'h59, 0, 9'h000, 8'h00,  0, 4);
        tv[19] = mk(8'h10, 0, 9'h000, 8'h00,  0, 4);
        tv[20] = mk(8'h10, 0, 9'h000, 8'h00,  0, 0);
        tv[21] = mk(8'h1B, 0, 9'h000, 8'h00,  0, 0);
        tv[22] = mk(8'h59, 0, 9'h000, 8'h00,  0, 0);
        tv[23] = mk(8'h7F, 0, 9'h000, 8'h00,  0, 0);
        tv[24] = mk(8'h7F, 0, 9'h000, 8'h00, 39, 7);
        tv[25] = mk(8'h1B, 0, 9'h000, 8'h00, 39, 7);
        tv[26] = mk(8'h58, 0, 9'h000, 8'h00, 39, 7);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_row_base", row_base, 0);
        chk("rst_cursor_x", cursor_x, 0);
        chk("rst_cursor_y", cursor_y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);

        // Two-cycle write latency for a printable byte.
        expect_wr(9'h000, 8'h41);
        send(8'h41);
        chk("lat_k", wr_en, 0);
        @(posedge clk);
        #1 chk("lat_k1", wr_en, 0);
        @(posedge clk);
        #1;
        chk("lat_k2_en", wr_en, 1);
        chk("lat_k2_addr", wr_addr, 9'h000);
        chk("lat_k2_data", wr_data, 8'h41);
        chk("lat_k2_cx", cursor_x, 1);
        @(posedge clk);
        #1 chk("lat_k3_en", wr_en, 0);

        for (int i = 0; i < 27; i++) begin
            if (tv[i].w) expect_wr(tv[i].a, tv[i].d);
            send(tv[i].b);
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("tv%0d_cx", i), cursor_x, tv[i].cx);
            chk($sformatf("tv%0d_cy", i), cursor_y, tv[i].cy);
        end
        chk("tv_drain", exp_q.size(), 0);

        // Scroll from row 7: new bottom is physical row 0.
        for (int c = 0; c < 40; c++) expect_wr({3'd0, 6'(c)}, 8'h20);
        send(8'h0A);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("scr_base", row_base, 1);
        chk("scr_noclr_yet", wr_en, 0);
        @(posedge clk);
        #1;
        chk("scr_first_wr", wr_en, 1);
        chk("scr_busy", busy, 1);
        wait_drain(100);
        repeat (2) @(posedge clk);
        #1;
        chk("scr_busy_done", busy, 0);
        chk("scr_cx", cursor_x, 39);
        chk("scr_cy", cursor_y, 7);

        // Column wrap on the bottom row scrolls again.
        expect_wr(9'h027, 8'h57);
        for (int c = 0; c < 40; c++) expect_wr({3'd1, 6'(c)}, 8'h20);
        send(8'h57);
        wait_drain(100);
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_base", row_base, 2);
        chk("wrap_cx", cursor_x, 0);
        chk("wrap_cy", cursor_y, 7);

        // Erase to end of line from column 36.
        for (int c = 36; c < 40; c++) expect_wr({3'd1, 6'(c)}, 8'h20);
        send(8'h1B);
        send(8'h59);
        send(8'h27);
        send(8'h44);
        send(8'h1B);
        send(8'h4B);
        wait_drain(50);
        repeat (2) @(posedge clk);
        #1;
        chk("eol_cx", cursor_x, 36);
        chk("eol_cy", cursor_y, 7);

        // Full clear with bytes trickling in at line rate.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 40; c++)
                expect_wr({3'(r), 6'(c)}, 8'h20);
        for (int i = 0; i < 8; i++) expect_wr(9'(i), 8'(8'h61 + i));
        send(8'h0C);
        repeat (3) @(posedge clk);
        #1 chk("cls_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            repeat (160) @(posedge clk);
            send(8'(8'h61 + i));
        end
        wait_drain(1000);
        repeat (2) @(posedge clk);
        #1;
        chk("cls_base", row_base, 0);
        chk("cls_cx", cursor_x, 8);
        chk("cls_cy", cursor_y, 0);
        chk("cls_ovf", overflow, 0);

        // Overflow during a clear, then reset mid-clear.
        mon_on = 1'b0;
        send(8'h0C);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_data   = 8'(8'h30 + i);
            rx_strobe = 1'b1;
        end
        @(negedge clk);
        rx_strobe = 1'b0;
        @(posedge clk);
        #1 chk("ovf_at8", overflow, 0);
        send(8'h39);
        #1;
        chk("ovf_at9", overflow, 1);
        chk("ovf_busy", busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_wr_en", wr_en, 0);
        chk("mrst_wr_addr", wr_addr, 0);
        chk("mrst_wr_data", wr_data, 0);
        chk("mrst_base", row_base, 0);
        chk("mrst_cx", cursor_x, 0);
        chk("mrst_cy", cursor_y, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ovf", overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_wr_en", wr_en, 0);
        chk("post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
